// File: rtl/uart_parity_engine_if.sv
// Bundled control/data/status signals of the UART parity generator/checker.
// The master side drives frames and modes; the slave side (the engine) returns results.
interface uart_parity_engine_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 8
);
  logic                  par_en_parity;
  logic [1:0]            par_mode_parity;
  logic                  chk_mode_parity;
  logic [DATA_WIDTH-1:0] p_data_parity;
  logic                  rx_par_bit_parity;
  logic                  data_valid_parity;
  logic                  clr_err_parity;
  logic                  par_bit_parity;
  logic                  par_valid_parity;
  logic                  par_err_parity;
  logic                  err_sticky_parity;
  logic [CNT_WIDTH-1:0]  err_cnt_parity;
  logic [CNT_WIDTH-1:0]  frm_cnt_parity;

  modport master (
    output par_en_parity, par_mode_parity, chk_mode_parity, p_data_parity,
           rx_par_bit_parity, data_valid_parity, clr_err_parity,
    input  par_bit_parity, par_valid_parity, par_err_parity, err_sticky_parity,
           err_cnt_parity, frm_cnt_parity
  );

  modport slave (
    input  par_en_parity, par_mode_parity, chk_mode_parity, p_data_parity,
           rx_par_bit_parity, data_valid_parity, clr_err_parity,
    output par_bit_parity, par_valid_parity, par_err_parity, err_sticky_parity,
           err_cnt_parity, frm_cnt_parity
  );
endinterface

// File: rtl/uart_parity_engine.sv
// Parametrised UART parity generator (TX) / checker (RX) with saturating error statistics.
// Two stages: capture of data/modes, then a registered result one cycle later.
module uart_parity_engine #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                 clk_parity,
  input  logic                 rst_parity,
  uart_parity_engine_if.slave  bus
);

  typedef enum logic [1:0] {
    PAR_EVEN  = 2'b00,
    PAR_ODD   = 2'b01,
    PAR_MARK  = 2'b10,
    PAR_SPACE = 2'b11
  } par_mode_e;

  // Capture stage
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  rx_q, rx_d;
  par_mode_e             mode_q, mode_d;
  logic                  chk_q, chk_d;
  logic                  cap_q, cap_d;

  // Result stage
  logic                  par_bit_q, par_bit_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic                  sticky_q, sticky_d;
  logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
  logic [CNT_WIDTH-1:0]  frm_cnt_q, frm_cnt_d;

  logic capture;
  logic exp_bit;
  logic mismatch;
  logic chk_res;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign capture = bus.data_valid_parity & bus.par_en_parity;

  always_comb begin
    exp_bit = 1'b0;
    case (mode_q)
      PAR_EVEN:  exp_bit = ^data_q;
      PAR_ODD:   exp_bit = ~(^data_q);
      PAR_MARK:  exp_bit = 1'b1;
      PAR_SPACE: exp_bit = 1'b0;
      default:   exp_bit = 1'b0;
    endcase
  end

  assign mismatch = exp_bit ^ rx_q;
  assign chk_res  = cap_q & chk_q;

  always_comb begin
    data_d    = data_q;
    rx_d      = rx_q;
    mode_d    = mode_q;
    chk_d     = chk_q;
    cap_d     = capture;
    if (capture) begin
      data_d = bus.p_data_parity;
      rx_d   = bus.rx_par_bit_parity;
      mode_d = par_mode_e'(bus.par_mode_parity);
      chk_d  = bus.chk_mode_parity;
    end

    par_bit_d = cap_q ? exp_bit : par_bit_q;
    valid_d   = cap_q;
    err_d     = chk_res & mismatch;

    // A clear on the same edge as a check result wipes history first, then counts the result.
    frm_cnt_d = bus.clr_err_parity ? '0   : frm_cnt_q;
    err_cnt_d = bus.clr_err_parity ? '0   : err_cnt_q;
    sticky_d  = bus.clr_err_parity ? 1'b0 : sticky_q;
    if (chk_res) begin
      frm_cnt_d = sat_inc(frm_cnt_d);
      if (mismatch) begin
        err_cnt_d = sat_inc(err_cnt_d);
        sticky_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_parity or negedge rst_parity) begin
    if (!rst_parity) begin
      data_q    <= '0;
      rx_q      <= 1'b0;
      mode_q    <= PAR_EVEN;
      chk_q     <= 1'b0;
      cap_q     <= 1'b0;
      par_bit_q <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      sticky_q  <= 1'b0;
      err_cnt_q <= '0;
      frm_cnt_q <= '0;
    end else begin
      data_q    <= data_d;
      rx_q      <= rx_d;
      mode_q    <= mode_d;
      chk_q     <= chk_d;
      cap_q     <= cap_d;
      par_bit_q <= par_bit_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      sticky_q  <= sticky_d;
      err_cnt_q <= err_cnt_d;
      frm_cnt_q <= frm_cnt_d;
    end
  end

  // Disable masks the visible bit only; the held result returns on re-enable.
  assign bus.par_bit_parity    = par_bit_q & bus.par_en_parity;
  assign bus.par_valid_parity  = valid_q;
  assign bus.par_err_parity    = err_q;
  assign bus.err_sticky_parity = sticky_q;
  assign bus.err_cnt_parity    = err_cnt_q;
  assign bus.frm_cnt_parity    = frm_cnt_q;

endmodule

// File: tb/tb_uart_parity_engine.sv
// Self-checking bench for uart_parity_engine: directed plan plus randomized frames
// against a parity-counting reference model; a second narrow instance covers DW=7/CNT=2.
module tb_uart_parity_engine;

  logic clk;
  logic rst_n;

  uart_parity_engine_if #(.DATA_WIDTH(8), .CNT_WIDTH(8)) ifa ();
  uart_parity_engine_if #(.DATA_WIDTH(7), .CNT_WIDTH(2)) ifb ();

  uart_parity_engine #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut_a (
    .clk_parity (clk),
    .rst_parity (rst_n),
    .bus        (ifa)
  );

  uart_parity_engine #(.DATA_WIDTH(7), .CNT_WIDTH(2)) dut_b (
    .clk_parity (clk),
    .rst_parity (rst_n),
    .bus        (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state for dut_a
  bit p_cap, p_bit, p_chk, p_rx;
  bit m_bit, m_valid, m_errp, m_sticky;
  int m_frm, m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_parity(input bit [1:0] mode, input int unsigned ones);
    case (mode)
      2'd0:    return bit'(ones % 2);
      2'd1:    return bit'(1 - (ones % 2));
      2'd2:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    p_cap = 0; p_bit = 0; p_chk = 0; p_rx = 0;
    m_bit = 0; m_valid = 0; m_errp = 0; m_sticky = 0;
    m_frm = 0; m_err = 0;
  endtask

  task automatic step_a(input bit en, input bit valid, input bit [1:0] mode, input bit chkm,
                        input bit [7:0] data, input bit rx, input bit clr);
    bit n_cap, n_bit;
    ifa.par_en_parity     = en;
    ifa.data_valid_parity = valid;
    ifa.par_mode_parity   = mode;
    ifa.chk_mode_parity   = chkm;
    ifa.p_data_parity     = data;
    ifa.rx_par_bit_parity = rx;
    ifa.clr_err_parity    = clr;
    n_cap = valid && en;
    n_bit = ref_parity(mode, $countones(data));
    tick();
    if (clr) begin
      m_frm = 0; m_err = 0; m_sticky = 0;
    end
    m_errp  = 0;
    m_valid = p_cap;
    if (p_cap) begin
      m_bit = p_bit;
      if (p_chk) begin
        m_frm = (m_frm < 255) ? m_frm + 1 : 255;
        if (p_bit != p_rx) begin
          m_err    = (m_err < 255) ? m_err + 1 : 255;
          m_sticky = 1;
          m_errp   = 1;
        end
      end
    end
    chk("a_par_bit", ifa.par_bit_parity, en ? m_bit : 1'b0);
    chk("a_valid",   ifa.par_valid_parity, m_valid);
    chk("a_err",     ifa.par_err_parity, m_errp);
    chk("a_sticky",  ifa.err_sticky_parity, m_sticky);
    chk("a_err_cnt", ifa.err_cnt_parity, m_err);
    chk("a_frm_cnt", ifa.frm_cnt_parity, m_frm);
    p_cap = n_cap; p_bit = n_bit; p_chk = chkm; p_rx = rx;
  endtask

  task automatic step_b(input bit valid, input bit chkm, input bit [6:0] data, input bit rx);
    ifb.par_en_parity     = 1'b1;
    ifb.data_valid_parity = valid;
    ifb.par_mode_parity   = 2'd0;
    ifb.chk_mode_parity   = chkm;
    ifb.p_data_parity     = data;
    ifb.rx_par_bit_parity = rx;
    ifb.clr_err_parity    = 1'b0;
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a_bit"},   ifa.par_bit_parity, 0);
    chk({tag, "_a_valid"}, ifa.par_valid_parity, 0);
    chk({tag, "_a_err"},   ifa.par_err_parity, 0);
    chk({tag, "_a_stk"},   ifa.err_sticky_parity, 0);
    chk({tag, "_a_ecnt"},  ifa.err_cnt_parity, 0);
    chk({tag, "_a_fcnt"},  ifa.frm_cnt_parity, 0);
    chk({tag, "_b_valid"}, ifb.par_valid_parity, 0);
    chk({tag, "_b_ecnt"},  ifb.err_cnt_parity, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    ifa.par_en_parity = 1'b1; ifa.data_valid_parity = 1'b0; ifa.par_mode_parity = 2'd0;
    ifa.chk_mode_parity = 1'b0; ifa.p_data_parity = '0; ifa.rx_par_bit_parity = 1'b0;
    ifa.clr_err_parity = 1'b0;
    ifb.par_en_parity = 1'b1; ifb.data_valid_parity = 1'b0; ifb.par_mode_parity = 2'd0;
    ifb.chk_mode_parity = 1'b0; ifb.p_data_parity = '0; ifb.rx_par_bit_parity = 1'b0;
    ifb.clr_err_parity = 1'b0;
    model_reset();

    tick(); tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Narrow instance: DW=7 even parity, then counter saturation at 3
    step_b(1, 0, 7'h7F, 0);
    step_b(0, 0, 7'h00, 0);
    chk("b_dw7_bit",   ifb.par_bit_parity, 1);
    chk("b_dw7_valid", ifb.par_valid_parity, 1);
    for (int i = 0; i < 5; i++) step_b(1, 1, 7'h7F, 0);
    step_b(0, 1, 7'h00, 0);
    chk("b_sat_err", ifb.err_cnt_parity, 3);
    chk("b_sat_frm", ifb.frm_cnt_parity, 3);
    chk("b_sat_stk", ifb.err_sticky_parity, 1);

    // Generate mode, even, back-to-back
    step_a(1, 1, 2'd0, 0, 8'hA5, 0, 0);
    step_a(1, 1, 2'd0, 0, 8'h07, 0, 0);
    chk("gen_a5_bit", ifa.par_bit_parity, 0);
    chk("gen_a5_vld", ifa.par_valid_parity, 1);
    step_a(1, 0, 2'd0, 0, 8'h00, 0, 0);
    chk("gen_07_bit", ifa.par_bit_parity, 1);
    chk("gen_07_vld", ifa.par_valid_parity, 1);
    chk("gen_ecnt",   ifa.err_cnt_parity, 0);

    // Odd / mark, enable gating, blocked capture, space
    step_a(1, 1, 2'd1, 0, 8'hA5, 0, 0);
    step_a(1, 0, 2'd0, 0, 8'h00, 0, 0);
    chk("odd_bit", ifa.par_bit_parity, 1);
    step_a(1, 1, 2'd2, 0, 8'hA5, 0, 0);
    step_a(1, 0, 2'd0, 0, 8'h00, 0, 0);
    chk("mark_bit", ifa.par_bit_parity, 1);
    step_a(0, 0, 2'd0, 0, 8'h00, 0, 0);
    chk("dis_bit", ifa.par_bit_parity, 0);
    step_a(0, 1, 2'd3, 0, 8'hA5, 0, 0);
    step_a(1, 0, 2'd0, 0, 8'h00, 0, 0);
    chk("reen_bit",    ifa.par_bit_parity, 1);
    chk("blocked_vld", ifa.par_valid_parity, 0);
    step_a(1, 1, 2'd3, 0, 8'hA5, 0, 0);
    step_a(1, 0, 2'd0, 0, 8'h00, 0, 0);
    chk("space_bit", ifa.par_bit_parity, 0);

    // Check mode, even
    step_a(1, 1, 2'd0, 1, 8'h07, 1, 0);
    step_a(1, 1, 2'd0, 1, 8'h07, 0, 0);
    chk("chk1_err", ifa.par_err_parity, 0);
    step_a(1, 1, 2'd0, 1, 8'hFF, 1, 0);
    chk("chk2_err", ifa.par_err_parity, 1);
    step_a(1, 0, 2'd0, 0, 8'h00, 0, 0);
    chk("chk3_err", ifa.par_err_parity, 1);
    chk("chk_ecnt", ifa.err_cnt_parity, 2);
    chk("chk_fcnt", ifa.frm_cnt_parity, 3);
    chk("chk_stk",  ifa.err_sticky_parity, 1);

    // Clear coincident with a mismatching result, then a clear alone
    step_a(1, 1, 2'd0, 1, 8'h07, 0, 0);
    step_a(1, 0, 2'd0, 0, 8'h00, 0, 1);
    chk("clr_hit_ecnt", ifa.err_cnt_parity, 1);
    chk("clr_hit_fcnt", ifa.frm_cnt_parity, 1);
    chk("clr_hit_stk",  ifa.err_sticky_parity, 1);
    step_a(1, 0, 2'd0, 0, 8'h00, 0, 1);
    chk("clr_ecnt", ifa.err_cnt_parity, 0);
    chk("clr_fcnt", ifa.frm_cnt_parity, 0);
    chk("clr_stk",  ifa.err_sticky_parity, 0);

    // Enable dropped the cycle after capture: pulse survives, bit masked
    step_a(1, 1, 2'd1, 0, 8'hA5, 0, 0);
    step_a(0, 0, 2'd0, 0, 8'h00, 0, 0);
    chk("late_dis_vld", ifa.par_valid_parity, 1);
    chk("late_dis_bit", ifa.par_bit_parity, 0);
    step_a(1, 0, 2'd0, 0, 8'h00, 0, 0);
    chk("late_dis_held", ifa.par_bit_parity, 1);

    // Reset asserted with a result in flight
    step_a(1, 1, 2'd0, 1, 8'h07, 0, 0);
    ifa.data_valid_parity = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    tick();
    chk("midrst_vld", ifa.par_valid_parity, 0);
    rst_n = 1'b1;
    model_reset();
    step_a(1, 0, 2'd0, 0, 8'h00, 0, 0);
    chk("post_rst_vld", ifa.par_valid_parity, 0);
    step_a(1, 1, 2'd0, 0, 8'h07, 0, 0);
    step_a(1, 0, 2'd0, 0, 8'h00, 0, 0);
    chk("post_rst_bit", ifa.par_bit_parity, 1);
    chk("post_rst_v2",  ifa.par_valid_parity, 1);

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      step_a(bit'($urandom_range(0, 9) != 0),
             bit'($urandom_range(0, 3) != 0),
             2'($urandom_range(0, 3)),
             bit'($urandom_range(0, 1)),
             8'($urandom),
             bit'($urandom_range(0, 1)),
             bit'($urandom_range(0, 19) == 0));
    end
    step_a(1, 0, 2'd0, 0, 8'h00, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_parity_engine.md
# uart_parity_engine

Parametrised parity generator/checker for the UART datapath, replacing the fixed 8-bit, TX-only parity calculator. In generate mode it computes the frame parity bit for the TX serialiser. In check mode it compares the received parity bit from the RX deserialiser against the computed parity and keeps error statistics. Supported parity types are even, odd, mark and space. Data is captured on a valid strobe and a registered result is produced one cycle later.

## Interface
Parameters:
- DATA_WIDTH, 8, frame data width; legal range 5..9.
- CNT_WIDTH, 8, width of the frame and error counters.

Ports:
- clk_parity  in  1  block clock.
- rst_parity  in  1  asynchronous, active-low reset.
- par_en_parity  in  1  parity enable; when low, captures are blocked and par_bit_parity is 0.
- par_mode_parity  in  2  parity type: 00 even, 01 odd, 10 mark (always 1), 11 space (always 0).
- chk_mode_parity  in  1  0 = generate (TX), 1 = check (RX).
- p_data_parity  in  DATA_WIDTH  frame data.
- rx_par_bit_parity  in  1  received parity bit; used only in check mode.
- data_valid_parity  in  1  capture strobe for p_data_parity and rx_par_bit_parity.
- clr_err_parity  in  1  synchronous clear of the counters and the sticky error flag.
- par_bit_parity  out  1  computed/expected parity bit.
- par_valid_parity  out  1  one-cycle pulse when a new result is available.
- par_err_parity  out  1  one-cycle mismatch pulse, aligned with par_valid_parity; check mode only.
- err_sticky_parity  out  1  set by any mismatch; held until cleared.
- err_cnt_parity  out  CNT_WIDTH  mismatch count, saturating.
- frm_cnt_parity  out  CNT_WIDTH  count of checked frames, saturating.

## Operation
- Capture condition: `data_valid_parity & par_en_parity` sampled at a rising clock edge.
  - On capture, the following are latched: data, rx_par_bit_parity, par_mode_parity and chk_mode_parity.
  - Mode inputs may change freely between captures. Changes do not affect a result already in flight.
- Parity computation: x = XOR-reduce of the latched data (all DATA_WIDTH bits).
  - Even: bit = x.
  - Odd: bit = ~x.
  - Mark: bit = 1.
  - Space: bit = 0.
- par_bit_parity:
  - Registered; updated on the cycle after capture.
  - Holds its value until the next capture.
  - Gated to 0 combinationally while par_en_parity is low. The register keeps its value and reappears when par_en_parity returns high.
- Generate mode:
  - par_valid_parity pulses on the cycle after capture.
  - par_err_parity stays 0.
  - Counters and sticky flag are unchanged.
- Check mode:
  - par_err_parity = (expected bit != latched rx bit), pulsed together with par_valid_parity.
  - frm_cnt_parity increments by 1 per checked frame.
  - err_cnt_parity increments by 1 per mismatch.
  - err_sticky_parity is set on any mismatch.
- Saturation: both counters stop at 2^CNT_WIDTH-1 and never wrap.
- clr_err_parity:
  - Zeroes frm_cnt_parity, err_cnt_parity and err_sticky_parity on the next edge.
  - If a check result is being written on that same edge, the clear applies first and the new result is then counted. Result: frm_cnt=1; err_cnt=1 and sticky=1 if mismatched, otherwise 0.
- Deasserting par_en_parity:
  - In the same cycle as data_valid_parity: no capture, no pulse.
  - In the cycle after a capture: the pulse still occurs, but par_bit_parity reads 0.

## Timing
- Latency: capture edge N -> outputs valid after edge N+1 (1 cycle).
- Throughput: one capture per cycle; back-to-back data_valid_parity produces back-to-back pulses.
- There is no backpressure: the block is always ready.
- Reset (asynchronous assert, synchronous release by the system) sets every register and output to 0:
  - par_bit_parity, par_valid_parity, par_err_parity, err_sticky_parity, err_cnt_parity, frm_cnt_parity.
  - The latched data, rx bit and modes.
- Reset asserted mid-operation: any pending pulse is dropped, and no pulse follows reset release.
- clr_err_parity takes 1 cycle; the cleared values are visible after the next edge.

## Test plan
- Generate mode, DATA_WIDTH=8, even:
  - 0xA5 -> par_bit=0.
  - Then 0x07 on the next cycle -> par_bit=1.
  - Two consecutive par_valid pulses; err_cnt=0.
- Odd, mark and space with data 0xA5 -> par_bit = 1, 1, 0 respectively.
  - Disable par_en_parity after the result -> par_bit reads 0.
  - Re-enable -> par_bit reads the held value again.
- Check mode, even:
  - Three frames: 0x07 with rx=1, 0x07 with rx=0, 0xFF with rx=1.
  - Required: par_err pulses 0,1,1; err_cnt=2; frm_cnt=3; sticky=1.
- clr_err_parity in the same cycle as a mismatching result -> err_cnt=1, frm_cnt=1, sticky=1.
  - A clear alone on the next cycle -> all three read 0.
- Saturation with CNT_WIDTH=2: five mismatching frames -> err_cnt=3 and frm_cnt=3, no wrap.
  - Separate build with DATA_WIDTH=7: 0x7F, even -> par_bit=1.
- Reset asserted in the cycle after a capture -> no par_valid pulse; all outputs 0.
  - After reset release, the next capture behaves normally.
